// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Byte-serial UART transmitter (8N1 / 8N2, LSB first) with a one-byte
// holding register in front of the shift register, so the CPU can queue the
// next byte while the current frame is on the line.
//
// Ports
//   sysclk    : clock, all logic on the rising edge
//   reset     : synchronous, active-high reset; aborts any frame in flight
//   TX_DATA   : byte to send, sampled only when TX_EN is accepted
//   TX_EN     : one-cycle write strobe, accepted only while TX_STATUS=1
//   TX_STATUS : 1 = holding register empty
//   TX_BUSY   : 1 = frame in progress
//   TX_DONE   : one-cycle pulse when the final stop bit completes
//   UART_TX   : registered serial line, idles high
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for the holding register to fill
// ST_START | start bit (line low) for one bit period
// ST_DATA  | eight data bits, bit 0 first, one bit period each
// ST_STOP  | line high for STOP_BITS bit periods, then done pulse

module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int STOP_BITS    = 1
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic [7:0] TX_DATA,
   input  logic       TX_EN,
   output logic       TX_STATUS,
   output logic       TX_BUSY,
   output logic       TX_DONE,
   output logic       UART_TX
);

   localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
   localparam int CNT_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

   // The bit timer is a down-counter reloaded at every bit boundary, so each
   // bit lasts exactly CLKS_PER_BIT cycles and no error accumulates.
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_CLKS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]       state;
   logic             hold_valid;
   logic [7:0]       hold_data;
   logic [7:0]       shifter;
   logic [2:0]       bit_idx;
   logic [CNT_W-1:0] baud_cnt;
   logic             tx_q;
   logic             done_q;

   assign TX_STATUS = ~hold_valid;
   assign TX_BUSY   = (state != ST_IDLE);
   assign TX_DONE   = done_q;
   assign UART_TX   = tx_q;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state      <= ST_IDLE;
         hold_valid <= 1'b0;
         hold_data  <= 8'h00;
         shifter    <= 8'h00;
         bit_idx    <= 3'd0;
         baud_cnt   <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Accept only into an empty hold; the hold-to-shifter transfer below
         // requires a full hold, so the two never collide.
         if (TX_EN && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= TX_DATA;
         end

         case (state)
            ST_IDLE: begin
               if (hold_valid) begin
                  state      <= ST_START;
                  shifter    <= hold_data;
                  hold_valid <= 1'b0;
                  tx_q       <= 1'b0;
                  baud_cnt   <= BIT_LOAD;
               end
            end

            ST_START: begin
               if (baud_cnt == '0) begin
                  state    <= ST_DATA;
                  tx_q     <= shifter[0];
                  baud_cnt <= BIT_LOAD;
               end else begin
                  baud_cnt <= baud_cnt - CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (baud_cnt == '0) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state    <= ST_STOP;
                     tx_q     <= 1'b1;
                     baud_cnt <= STOP_LOAD;
                  end else begin
                     tx_q     <= shifter[1];
                     shifter  <= {1'b0, shifter[7:1]};
                     baud_cnt <= BIT_LOAD;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (baud_cnt == '0) begin
                  done_q <= 1'b1;
                  // A queued byte starts immediately: no extra idle bit.
                  if (hold_valid) begin
                     state      <= ST_START;
                     shifter    <= hold_data;
                     hold_valid <= 1'b0;
                     tx_q       <= 1'b0;
                     baud_cnt   <= BIT_LOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine at CLKS_PER_BIT=4.
// dut1 runs 8N1, dut2 runs 8N2.

module tb_uart_tx_engine;

   localparam int CPB = 4;
   localparam int NCAP = 128;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   logic       rst1, en1, rst2, en2;
   logic [7:0] d1, d2;
   logic       st1, busy1, done1, tx1;
   logic       st2, busy2, done2, tx2;

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .sysclk(sysclk), .reset(rst1), .TX_DATA(d1), .TX_EN(en1),
      .TX_STATUS(st1), .TX_BUSY(busy1), .TX_DONE(done1), .UART_TX(tx1)
   );

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .sysclk(sysclk), .reset(rst2), .TX_DATA(d2), .TX_EN(en2),
      .TX_STATUS(st2), .TX_BUSY(busy2), .TX_DONE(done2), .UART_TX(tx2)
   );

   // exp = {UART_TX, TX_STATUS, TX_BUSY, TX_DONE} after the edge
   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] data;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic cl [0:NCAP-1];
   logic cs [0:NCAP-1];
   logic cb [0:NCAP-1];
   logic cd [0:NCAP-1];
   logic ew [0:NCAP-1];
   logic ed [0:NCAP-1];

   task automatic add(input int n, input logic rst, input logic en,
                      input logic [7:0] data, input logic [3:0] exp);
      for (int i = 0; i < n; i++) tbl.push_back('{rst, en, data, exp});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic clear_expect();
      for (int i = 0; i < NCAP; i++) begin
         ew[i] = 1'b1;
         ed[i] = 1'b0;
      end
   endtask

   // Expected line for one frame whose start bit begins after edge s.
   task automatic paint_frame(input int s, input logic [7:0] b);
      for (int o = 0; o < CPB; o++) ew[s + o] = 1'b0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < CPB; j++) ew[s + CPB + CPB*k + j] = b[k];
   endtask

   task automatic compare_waves(input string name, input int n);
      int bad_l;
      int bad_d;
      bad_l = -1;
      bad_d = -1;
      for (int i = 0; i < n; i++) begin
         if (cl[i] !== ew[i] && bad_l < 0) bad_l = i;
         if (cd[i] !== ed[i] && bad_d < 0) bad_d = i;
      end
      n_checks++;
      if (bad_l >= 0) begin
         n_fail++;
         $display("FAIL %s_line: cycle %0d got %b, required %b", name, bad_l, cl[bad_l], ew[bad_l]);
      end
      n_checks++;
      if (bad_d >= 0) begin
         n_fail++;
         $display("FAIL %s_done: cycle %0d got %b, required %b", name, bad_d, cd[bad_d], ed[bad_d]);
      end
   endtask

   // Mid-bit sampling receiver for a frame starting after edge s.
   function automatic logic [8:0] decode(input int s);
      logic [8:0] r;
      for (int k = 0; k < 8; k++) r[k] = cl[s + CPB + CPB*k + CPB/2];
      r[8] = cl[s + 9*CPB + CPB/2];
      return r;
   endfunction

   task automatic step_cap(input int sel, input int c);
      @(posedge sysclk);
      @(negedge sysclk);
      if (sel == 1) begin
         cl[c] = tx1; cs[c] = st1; cb[c] = busy1; cd[c] = done1;
      end else begin
         cl[c] = tx2; cs[c] = st2; cb[c] = busy2; cd[c] = done2;
      end
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      en1 = 1'b0;  en2 = 1'b0;
      d1 = 8'h00;  d2 = 8'h00;
      @(negedge sysclk);

      // Reset, single byte 0x07, then reset in the middle of a frame with a
      // byte queued.
      add(3,  1'b1, 1'b0, 8'h00, 4'b1100);
      add(2,  1'b0, 1'b0, 8'h00, 4'b1100);
      add(1,  1'b0, 1'b1, 8'h07, 4'b1000);
      add(4,  1'b0, 1'b0, 8'hAA, 4'b0110);
      add(12, 1'b0, 1'b0, 8'hAA, 4'b1110);
      add(20, 1'b0, 1'b0, 8'hAA, 4'b0110);
      add(4,  1'b0, 1'b0, 8'hAA, 4'b1110);
      add(1,  1'b0, 1'b0, 8'hAA, 4'b1101);
      add(2,  1'b0, 1'b0, 8'hAA, 4'b1100);
      add(1,  1'b0, 1'b1, 8'h0F, 4'b1000);
      add(4,  1'b0, 1'b0, 8'h00, 4'b0110);
      add(1,  1'b0, 1'b0, 8'h00, 4'b1110);
      add(1,  1'b0, 1'b1, 8'h33, 4'b1010);
      add(2,  1'b0, 1'b0, 8'h00, 4'b1010);
      add(3,  1'b1, 1'b0, 8'h00, 4'b1100);
      add(12, 1'b0, 1'b0, 8'h00, 4'b1100);

      for (int i = 0; i < tbl.size(); i++) begin
         rst1 = tbl[i].rst;
         en1  = tbl[i].en;
         d1   = tbl[i].data;
         @(posedge sysclk);
         @(negedge sysclk);
         check($sformatf("vec%0d", i), {28'd0, tx1, st1, busy1, done1}, {28'd0, tbl[i].exp});
      end
      en1 = 1'b0;

      // Back-to-back 0x07 / 0x02 with overflow writes of 0xFF while hold full.
      clear_expect();
      paint_frame(1, 8'h07);
      paint_frame(41, 8'h02);
      ed[41] = 1'b1;
      ed[81] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         en1 = (c == 0) || (c == 10) || (c == 11) || (c == 20);
         d1  = (c == 0) ? 8'h07 : (c == 10) ? 8'h02 : 8'hFF;
         step_cap(1, c);
      end
      en1 = 1'b0;
      compare_waves("b2b", 100);
      begin
         int held_bad;
         held_bad = -1;
         for (int c = 10; c <= 40; c++) if (cs[c] !== 1'b0 && held_bad < 0) held_bad = c;
         check("b2b_status_held_bad_cycle", held_bad, -1);
      end
      check("b2b_status_release", {31'd0, cs[41]}, 32'd1);
      check("b2b_no_gap", {30'd0, cl[40], cl[41]}, 32'b10);
      check("b2b_busy_last", {30'd0, cb[80], cb[81]}, 32'b10);
      check("b2b_rx_byte1", {23'd0, decode(1)}, {23'd0, 9'h107});
      check("b2b_rx_byte2", {23'd0, decode(41)}, {23'd0, 9'h102});

      // Accept on the same edge the frame ends; IDLE sends it one edge later.
      clear_expect();
      paint_frame(1, 8'h81);
      paint_frame(42, 8'h3C);
      ed[41] = 1'b1;
      ed[82] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         en1 = (c == 0) || (c == 41);
         d1  = (c == 0) ? 8'h81 : 8'h3C;
         step_cap(1, c);
      end
      en1 = 1'b0;
      compare_waves("endacc", 100);
      check("endacc_busy41", {31'd0, cb[41]}, 32'd0);
      check("endacc_status", {30'd0, cs[41], cs[42]}, 32'b01);
      check("endacc_rx_byte2", {23'd0, decode(42)}, {23'd0, 9'h13C});

      // 8N2 instance, byte 0x55.
      rst2 = 1'b0;
      @(posedge sysclk);
      @(negedge sysclk);
      check("n2_idle", {28'd0, tx2, st2, busy2, done2}, {28'd0, 4'b1100});
      clear_expect();
      paint_frame(1, 8'h55);
      ed[45] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         en2 = (c == 0);
         d2  = 8'h55;
         step_cap(2, c);
      end
      en2 = 1'b0;
      compare_waves("n2", 60);
      check("n2_busy_fall", {30'd0, cb[44], cb[45]}, 32'b10);
      check("n2_rx_byte", {23'd0, decode(1)}, {23'd0, 9'h155});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
